// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Instruction memory is combinational and based at PC_RESET.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_TOP   = 32'h0000_6FFC,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_pc,
  input  logic [31:0] im_rd,
  input  logic        stall,
  input  logic        exc_req,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] jr_target,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        id_fetch_err
);

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        fetch_err;
  } ifid_t;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4, br_off, br_tgt, j_tgt;
  logic        fetch_err;
  ifid_t       ifid_q, ifid_d;

  assign pc_plus4  = pc_q + 32'd4;
  // Redirect targets are formed from the instruction sitting in ID.
  assign br_off    = {{14{ifid_q.instr[15]}}, ifid_q.instr[15:0], 2'b00};
  assign br_tgt    = ifid_q.pc + 32'd4 + br_off;
  assign j_tgt     = {ifid_q.pc[31:28], ifid_q.instr[25:0], 2'b00};
  assign fetch_err = (pc_q[1:0] != 2'b00) || (pc_q < PC_RESET) || (pc_q > IM_TOP);

  always_comb begin
    pc_d = pc_plus4;
    if (exc_req) begin
      pc_d = EXC_VEC;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      case (npc_sel_e'(npc_sel))
        NPC_BR:  if (br_taken) pc_d = br_tgt;
        NPC_J:   pc_d = j_tgt;
        NPC_JR:  pc_d = jr_target;
        default: pc_d = pc_plus4;
      endcase
    end
  end

  // Exception flush wins over stall; the delay-slot fetch is never squashed by a redirect.
  always_comb begin
    ifid_d = ifid_q;
    if (exc_req) begin
      ifid_d = '0;
    end else if (!stall) begin
      ifid_d.instr     = fetch_err ? 32'h0 : im_rd;
      ifid_d.pc        = pc_q;
      ifid_d.valid     = 1'b1;
      ifid_d.fetch_err = fetch_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= PC_RESET;
      ifid_q <= '0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign im_pc        = pc_q;
  assign id_instr     = ifid_q.instr;
  assign id_pc        = ifid_q.pc;
  assign id_pc8       = ifid_q.pc + 32'd8;
  assign id_valid     = ifid_q.valid;
  assign id_fetch_err = ifid_q.fetch_err;

endmodule
